// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: FSM encoding and request-bundle widths.
package vram_arbiter_pkg;

    // Byte-enable lanes per request and width of the access-cycle counter.
    localparam int unsigned BE_WIDTH  = 2;
    localparam int unsigned CNT_WIDTH = 4;

    // Inactive (all high) value of the active-low byte-enable pins.
    localparam logic [BE_WIDTH-1:0] BE_PINS_IDLE = '1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StTurn   = 2'd2
    } state_e;

    // Requesters use active-high byte enables; the SRAM pins are active low.
    function automatic logic [BE_WIDTH-1:0] be_to_pins(input logic [BE_WIDTH-1:0] be);
        return ~be;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Two-port VRAM bus arbiter: Renderer (R) has priority, MPU (M) is protected from
// starvation by a burst limit. Every request becomes one timed SRAM cycle.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned MAX_REN_BURST = 4
) (
    input  logic                  clk,
    input  logic                  _reset,

    input  logic                  r_req,
    input  logic                  r_wr,
    input  logic [BE_WIDTH-1:0]   r_be,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_wdata,
    output logic                  r_ack,
    output logic [DATA_WIDTH-1:0] r_rdata,

    input  logic                  m_req,
    input  logic                  m_wr,
    input  logic [BE_WIDTH-1:0]   m_be,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_ack,
    output logic [DATA_WIDTH-1:0] m_rdata,

    output logic                  _vram_en,
    output logic                  _vram_rd,
    output logic                  _vram_wr,
    output logic [BE_WIDTH-1:0]   _vram_be,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_data_out,
    output logic                  vram_data_oe,
    input  logic [DATA_WIDTH-1:0] vram_data_in
);

    localparam int unsigned STARVE_WIDTH = $clog2(MAX_REN_BURST + 1);
    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(MAX_REN_BURST);
    localparam logic [CNT_WIDTH-1:0]    CNT_LAST   = CNT_WIDTH'(ACCESS_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [STARVE_WIDTH-1:0] starve_q, starve_d;
    logic                    sel_m_q, sel_m_d;

    logic                    en_n_q, en_n_d;
    logic                    rd_n_q, rd_n_d;
    logic                    wr_n_q, wr_n_d;
    logic [BE_WIDTH-1:0]     be_n_q, be_n_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    oe_q, oe_d;
    logic                    r_ack_q, r_ack_d;
    logic                    m_ack_q, m_ack_d;
    logic [DATA_WIDTH-1:0]   r_rdata_q, r_rdata_d;
    logic [DATA_WIDTH-1:0]   m_rdata_q, m_rdata_d;

    logic                    grant_r, grant_m;
    logic                    req_wr;
    logic [BE_WIDTH-1:0]     req_be;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;

    // Arbitration: R wins unless M is waiting and R has used up its burst allowance.
    always_comb begin
        grant_r   = r_req && (!m_req || (starve_q < STARVE_MAX));
        grant_m   = !grant_r && m_req;
        req_wr    = grant_m ? m_wr    : r_wr;
        req_be    = grant_m ? m_be    : r_be;
        req_addr  = grant_m ? m_addr  : r_addr;
        req_wdata = grant_m ? m_wdata : r_wdata;
    end

    // Next-state and registered-output logic. Bus registers hold their value by default,
    // so the granted request stays on the pins for the whole access without a copy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        sel_m_d   = sel_m_q;
        en_n_d    = en_n_q;
        rd_n_d    = rd_n_q;
        wr_n_d    = wr_n_q;
        be_n_d    = be_n_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        r_ack_d   = 1'b0;
        m_ack_d   = 1'b0;
        r_rdata_d = r_rdata_q;
        m_rdata_d = m_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_r || grant_m) begin
                    state_d = StAccess;
                    cnt_d   = '0;
                    sel_m_d = grant_m;
                    en_n_d  = 1'b0;
                    rd_n_d  = req_wr;
                    wr_n_d  = !req_wr;
                    be_n_d  = be_to_pins(req_be);
                    addr_d  = req_addr;
                    oe_d    = req_wr;
                    if (req_wr) begin
                        dout_d = req_wdata;
                    end
                    if (grant_m || !m_req) begin
                        starve_d = '0;
                    end else if (starve_q < STARVE_MAX) begin
                        starve_d = starve_q + STARVE_WIDTH'(1);
                    end
                end
            end

            StAccess: begin
                if (cnt_q == CNT_LAST) begin
                    // A read is identified by the write strobe being inactive.
                    if (wr_n_q) begin
                        if (sel_m_q) begin
                            m_rdata_d = vram_data_in;
                        end else begin
                            r_rdata_d = vram_data_in;
                        end
                    end
                    r_ack_d = !sel_m_q;
                    m_ack_d = sel_m_q;
                    en_n_d  = 1'b1;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    be_n_d  = BE_PINS_IDLE;
                    oe_d    = 1'b0;
                    // Writes need a dead cycle so the pad driver is off before the next access.
                    state_d = wr_n_q ? StIdle : StTurn;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            StTurn: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any access and parks the bus.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            starve_q  <= '0;
            sel_m_q   <= 1'b0;
            en_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            be_n_q    <= BE_PINS_IDLE;
            addr_q    <= '0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
            r_ack_q   <= 1'b0;
            m_ack_q   <= 1'b0;
            r_rdata_q <= '0;
            m_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            sel_m_q   <= sel_m_d;
            en_n_q    <= en_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            be_n_q    <= be_n_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            r_ack_q   <= r_ack_d;
            m_ack_q   <= m_ack_d;
            r_rdata_q <= r_rdata_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign _vram_en      = en_n_q;
    assign _vram_rd      = rd_n_q;
    assign _vram_wr      = wr_n_q;
    assign _vram_be      = be_n_q;
    assign vram_addr     = addr_q;
    assign vram_data_out = dout_q;
    assign vram_data_oe  = oe_q;
    assign r_ack         = r_ack_q;
    assign m_ack         = m_ack_q;
    assign r_rdata       = r_rdata_q;
    assign m_rdata       = m_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and random checks of vram_arbiter with hand-computed expectations.
module tb_vram_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          _reset = 1'b1;
    logic          r_req = 1'b0, r_wr = 1'b0, m_req = 1'b0, m_wr = 1'b0;
    logic [1:0]    r_be = 2'b11, m_be = 2'b11;
    logic [AW-1:0] r_addr = '0, m_addr = '0;
    logic [DW-1:0] r_wdata = '0, m_wdata = '0;
    logic          r_ack, m_ack;
    logic [DW-1:0] r_rdata, m_rdata;
    logic          _vram_en, _vram_rd, _vram_wr, vram_data_oe;
    logic [1:0]    _vram_be;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_data_out;
    logic [DW-1:0] vram_data_in = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(2), .MAX_REN_BURST(4)
    ) dut (
        .clk(clk), ._reset(_reset),
        .r_req(r_req), .r_wr(r_wr), .r_be(r_be), .r_addr(r_addr), .r_wdata(r_wdata),
        .r_ack(r_ack), .r_rdata(r_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        ._vram_en(_vram_en), ._vram_rd(_vram_rd), ._vram_wr(_vram_wr), ._vram_be(_vram_be),
        .vram_addr(vram_addr), .vram_data_out(vram_data_out), .vram_data_oe(vram_data_oe),
        .vram_data_in(vram_data_in)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] ctl;
        #2 _reset = 1'b0;
        r_req = 1'b1; r_wr = 1'b0; r_be = 2'b11; r_addr = 16'h0AB0;
        tick(); tick();
        ctl = {_vram_en, _vram_rd, _vram_wr, _vram_be, vram_data_oe, r_ack, m_ack};
        n_checks++;
        if (ctl !== 8'b1111_1000) begin
            n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 8'b1111_1000);
        end
        n_checks++;
        if ({vram_addr, vram_data_out, r_rdata, m_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {vram_addr, vram_data_out, r_rdata, m_rdata});
        end
        _reset = 1'b1;
        tick();
        n_checks++;
        if (_vram_en !== 1'b0 || _vram_rd !== 1'b0 || vram_addr !== 16'h0AB0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got en=%b rd=%b addr=%h want 0 0 0ab0",
                     _vram_en, _vram_rd, vram_addr);
        end
        vram_data_in = 16'h5151;
        tick(); tick();
        n_checks++;
        if (r_ack !== 1'b1 || r_rdata !== 16'h5151) begin
            n_fail++; $display("FAIL reset_first_ack: got ack=%b data=%h want 1 5151", r_ack, r_rdata);
        end
        r_req = 1'b0;
        tick();
    endtask

    task automatic test_m_read();
        m_req = 1'b1; m_wr = 1'b0; m_be = 2'b11; m_addr = 16'h0123;
        tick();
        n_checks++;
        if ({_vram_en, _vram_rd, _vram_wr, vram_data_oe, m_ack} !== 5'b00100 || vram_addr !== 16'h0123) begin
            n_fail++;
            $display("FAIL m_read_c1: got ctl=%b addr=%h want 00100 0123",
                     {_vram_en, _vram_rd, _vram_wr, vram_data_oe, m_ack}, vram_addr);
        end
        vram_data_in = 16'h1111;
        tick();
        n_checks++;
        if ({_vram_en, _vram_rd, m_ack} !== 3'b000) begin
            n_fail++; $display("FAIL m_read_c2: got %b want 000", {_vram_en, _vram_rd, m_ack});
        end
        vram_data_in = 16'hBEEF;
        tick();
        n_checks++;
        if (m_ack !== 1'b1 || m_rdata !== 16'hBEEF || r_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL m_read_ack: got ack=%b data=%h r_ack=%b want 1 beef 0", m_ack, m_rdata, r_ack);
        end
        n_checks++;
        if ({_vram_en, _vram_rd} !== 2'b11) begin
            n_fail++; $display("FAIL m_read_release: got %b want 11", {_vram_en, _vram_rd});
        end
        m_req = 1'b0;
        tick();
        n_checks++;
        if (m_ack !== 1'b0) begin
            n_fail++; $display("FAIL m_ack_pulse: got %b want 0", m_ack);
        end
    endtask

    task automatic test_r_write();
        int waited;
        r_req = 1'b1; r_wr = 1'b1; r_be = 2'b01; r_addr = 16'h0040; r_wdata = 16'hA55A;
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_checks++;
            if ({_vram_en, _vram_rd, _vram_wr, _vram_be, vram_data_oe} !== 6'b010101 ||
                vram_data_out !== 16'hA55A || vram_addr !== 16'h0040) begin
                n_fail++;
                $display("FAIL r_write_c%0d: got ctl=%b dout=%h addr=%h want 010101 a55a 0040", c,
                         {_vram_en, _vram_rd, _vram_wr, _vram_be, vram_data_oe}, vram_data_out, vram_addr);
            end
        end
        tick();
        n_checks++;
        if (r_ack !== 1'b1 || {_vram_en, _vram_wr, vram_data_oe} !== 3'b110) begin
            n_fail++;
            $display("FAIL r_write_ack: got ack=%b ctl=%b want 1 110", r_ack,
                     {_vram_en, _vram_wr, vram_data_oe});
        end
        r_req = 1'b0;
        // Raised during the turnaround cycle: the earliest grant is one cycle later.
        m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h0300;
        tick();
        n_checks++;
        if (r_ack !== 1'b0 || _vram_en !== 1'b1 || vram_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL r_write_turn: got ack=%b en=%b oe=%b want 0 1 0", r_ack, _vram_en, vram_data_oe);
        end
        tick();
        n_checks++;
        if (_vram_en !== 1'b0 || vram_addr !== 16'h0300) begin
            n_fail++; $display("FAIL turn_next_grant: got en=%b addr=%h want 0 0300", _vram_en, vram_addr);
        end
        waited = 0;
        while (m_ack !== 1'b1 && waited < 20) begin
            tick(); waited++;
        end
        n_checks++;
        if (m_ack !== 1'b1) begin
            n_fail++; $display("FAIL turn_m_ack_timeout: got 0 want 1");
        end
        m_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_m = 10'b10_0001_0000;
        logic [9:0] got_m = '0;
        int         when_g[10];
        int         ng = 0;
        int         ng_at_m_ack = -1;
        logic       prev_en = 1'b1;
        r_req = 1'b1; r_wr = 1'b0; r_addr = 16'h1000;
        m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h2000;
        for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
            tick();
            if (m_ack === 1'b1 && ng_at_m_ack < 0) ng_at_m_ack = ng;
            if (prev_en === 1'b1 && _vram_en === 1'b0) begin
                got_m[ng] = (vram_addr == 16'h2000);
                when_g[ng] = cyc;
                ng++;
            end
            prev_en = _vram_en;
        end
        n_checks++;
        if (ng != 10) begin
            n_fail++; $display("FAIL starve_grant_count: got %0d want 10", ng);
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (got_m[i] !== exp_m[i]) begin
                n_fail++; $display("FAIL starve_order[%0d]: got m=%b want m=%b", i, got_m[i], exp_m[i]);
            end
        end
        n_checks++;
        if (ng_at_m_ack < 1 || ng_at_m_ack > 5) begin
            n_fail++; $display("FAIL starve_m_ack: got after %0d grants want 1..5", ng_at_m_ack);
        end
        // Back-to-back reads: grant, two access cycles, ack cycle doubles as arbitration.
        n_checks++;
        if (when_g[1] - when_g[0] != 3) begin
            n_fail++; $display("FAIL back_to_back_gap: got %0d want 3", when_g[1] - when_g[0]);
        end
        r_req = 1'b0; m_req = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_drop_before_grant();
        int en_low = 0;
        int m_acks = 0;
        r_req = 1'b1; r_wr = 1'b0; r_addr = 16'h0500;
        tick();
        m_req = 1'b1; m_wr = 1'b1; m_addr = 16'h0600; m_wdata = 16'h7777;
        tick();
        m_req = 1'b0;
        tick();
        n_checks++;
        if (r_ack !== 1'b1) begin
            n_fail++; $display("FAIL drop_r_ack: got %b want 1", r_ack);
        end
        r_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (_vram_en === 1'b0) en_low++;
            if (m_ack === 1'b1) m_acks++;
        end
        n_checks++;
        if (en_low != 0 || m_acks != 0) begin
            n_fail++; $display("FAIL drop_ignored: got en_low=%0d m_acks=%0d want 0 0", en_low, m_acks);
        end
    endtask

    task automatic test_reset_mid_access();
        int m_acks = 0;
        m_req = 1'b1; m_wr = 1'b1; m_be = 2'b11; m_addr = 16'h0077; m_wdata = 16'h1234;
        tick();
        n_checks++;
        if (_vram_wr !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_started: got wr=%b want 0", _vram_wr);
        end
        #2 _reset = 1'b0;
        #1;
        n_checks++;
        if ({_vram_en, _vram_rd, _vram_wr, _vram_be, vram_data_oe} !== 6'b111110) begin
            n_fail++;
            $display("FAIL mid_reset_bus: got %b want 111110",
                     {_vram_en, _vram_rd, _vram_wr, _vram_be, vram_data_oe});
        end
        m_req = 1'b0;
        tick();
        _reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m_ack === 1'b1) m_acks++;
        end
        n_checks++;
        if (m_acks != 0) begin
            n_fail++; $display("FAIL mid_reset_no_ack: got %0d acks want 0", m_acks);
        end
        m_req = 1'b1; m_addr = 16'h0078; m_wdata = 16'h4321;
        tick();
        n_checks++;
        if (_vram_wr !== 1'b0 || vram_data_oe !== 1'b1 || vram_data_out !== 16'h4321 ||
            vram_addr !== 16'h0078) begin
            n_fail++;
            $display("FAIL after_reset_write: got wr=%b oe=%b dout=%h addr=%h want 0 1 4321 0078",
                     _vram_wr, vram_data_oe, vram_data_out, vram_addr);
        end
        tick(); tick();
        n_checks++;
        if (m_ack !== 1'b1) begin
            n_fail++; $display("FAIL after_reset_ack: got %b want 1", m_ack);
        end
        m_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random();
        int            r_issued = 0, r_acks = 0, m_issued = 0, m_acks = 0;
        logic [DW-1:0] prev_din;
        for (int cyc = 0; cyc < 500; cyc++) begin
            tick();
            prev_din = vram_data_in;
            n_checks++;
            if (_vram_rd === 1'b0 && _vram_wr === 1'b0) begin
                n_fail++; $display("FAIL rnd_rd_wr_overlap: got rd=0 wr=0 want not both 0 (cyc %0d)", cyc);
            end
            n_checks++;
            if (vram_data_oe === 1'b1 && _vram_wr !== 1'b0) begin
                n_fail++; $display("FAIL rnd_oe_without_wr: got oe=1 wr=%b want wr=0 (cyc %0d)", _vram_wr, cyc);
            end
            n_checks++;
            if ((r_ack === 1'b1 && r_req !== 1'b1) || (m_ack === 1'b1 && m_req !== 1'b1)) begin
                n_fail++;
                $display("FAIL rnd_spurious_ack: got r_ack=%b r_req=%b m_ack=%b m_req=%b (cyc %0d)",
                         r_ack, r_req, m_ack, m_req, cyc);
            end
            if (r_ack === 1'b1 && r_req === 1'b1 && !r_wr) begin
                n_checks++;
                if (r_rdata !== prev_din) begin
                    n_fail++; $display("FAIL rnd_r_rdata: got %h want %h", r_rdata, prev_din);
                end
            end
            if (m_ack === 1'b1 && m_req === 1'b1 && !m_wr) begin
                n_checks++;
                if (m_rdata !== prev_din) begin
                    n_fail++; $display("FAIL rnd_m_rdata: got %h want %h", m_rdata, prev_din);
                end
            end
            if (r_ack === 1'b1) begin
                r_req = 1'b0; r_acks++;
            end else if (!r_req && cyc < 440 && $urandom_range(0, 2) == 0) begin
                r_req = 1'b1; r_wr = $urandom_range(0, 1) == 1; r_be = 2'($urandom_range(1, 3));
                r_addr = 16'($urandom); r_wdata = 16'($urandom); r_issued++;
            end
            if (m_ack === 1'b1) begin
                m_req = 1'b0; m_acks++;
            end else if (!m_req && cyc < 440 && $urandom_range(0, 2) == 0) begin
                m_req = 1'b1; m_wr = $urandom_range(0, 1) == 1; m_be = 2'($urandom_range(1, 3));
                m_addr = 16'($urandom); m_wdata = 16'($urandom); m_issued++;
            end
            vram_data_in = 16'($urandom);
        end
        n_checks++;
        if (r_req !== 1'b0 || m_req !== 1'b0 || r_issued != r_acks || m_issued != m_acks) begin
            n_fail++;
            $display("FAIL rnd_ack_count: got r %0d/%0d m %0d/%0d acked/issued want all acked",
                     r_acks, r_issued, m_acks, m_issued);
        end
    endtask

    initial begin
        test_reset();
        test_m_read();
        test_r_write();
        test_starvation();
        test_drop_before_grant();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Owns the external VRAM bus and shares it between two requesters: the Renderer (port R) and the MPU (port M). Each request becomes one timed SRAM cycle on the bus.
- The Renderer has priority.
- A starvation limit guarantees the MPU eventually gets the bus.
- It sits in ChronoCube between the Renderer/MPU VRAM signals and the _vram_* pins. The top level only ties vram_data_out, vram_data_oe and vram_data_in to the inout vram_data.

Parameters:
ADDR_WIDTH, 16, VRAM address width (top level passes `VRAM_ADDR_WIDTH)
DATA_WIDTH, 16, VRAM data width
ACCESS_CYCLES, 2, clocks each access drives the bus (min 1, max 15)
MAX_REN_BURST, 4, max consecutive R grants while M is waiting (min 1)

Ports:
clk  in  1  system clock
_reset  in  1  reset; asynchronous, active-low
r_req  in  1  Renderer request
r_wr  in  1  1=write, 0=read
r_be  in  2  byte enables, active high
r_addr  in  ADDR_WIDTH  Renderer address
r_wdata  in  DATA_WIDTH  Renderer write data
r_ack  out  1  one-cycle completion pulse
r_rdata  out  DATA_WIDTH  read data, valid while r_ack=1
m_req, m_wr, m_be, m_addr, m_wdata, m_ack, m_rdata  same as the r_* ports, for the MPU
_vram_en  out  1  chip enable, active low
_vram_rd  out  1  output enable, active low
_vram_wr  out  1  write enable, active low
_vram_be  out  2  byte enables, active low
vram_addr  out  ADDR_WIDTH  bus address
vram_data_out  out  DATA_WIDTH  write data to the pad
vram_data_oe  out  1  1=drive the pad
vram_data_in  in  DATA_WIDTH  data from the pad

Behaviour:
- Reset (_reset=0, async): state=IDLE; _vram_en/_vram_rd/_vram_wr=1; _vram_be=2'b11; vram_addr=0; vram_data_out=0; vram_data_oe=0; r_ack=m_ack=0; r_rdata=m_rdata=0; starve count=0.
- All outputs are registered.
- Requester contract:
  - Hold req, wr, be, addr and wdata stable until ack.
  - ack pulses exactly one cycle.
  - req still high in the cycle after ack is a new request.
- FSM states: IDLE, ACCESS, TURN.
- IDLE, arbitration each cycle:
  - If r_req and (!m_req or starve<MAX_REN_BURST): grant R. If m_req, starve++; otherwise starve=0.
  - Else if m_req: grant M, starve=0.
  - Else stay in IDLE.
- Grant is taken in cycle N. From N+1 the bus is driven for ACCESS_CYCLES cycles (state ACCESS, 4-bit cycle counter):
  - _vram_en=0, vram_addr=addr, _vram_be=~be.
  - Read: _vram_rd=0, oe=0.
  - Write: _vram_wr=0, oe=1, vram_data_out=wdata.
- On the last ACCESS cycle:
  - Read: vram_data_in is sampled into rdata.
  - Next cycle: ack=1 for the granted port and all bus controls return to inactive.
  - Request-to-ack latency (grant taken immediately) = ACCESS_CYCLES+1 clocks.
- After the last ACCESS cycle:
  - After a write: go to TURN for one cycle (oe=0, controls inactive), then IDLE. The next grant is taken in the ack cycle+1.
  - After a read: go directly to IDLE. Arbitration happens in the ack cycle, so back-to-back reads run with one idle bus cycle between them.
- Overlap rules:
  - _vram_rd and _vram_wr are never both 0.
  - oe=1 only while _vram_wr=0.
- Simultaneous r_req and m_req with starve=0: R wins.
- After MAX_REN_BURST R grants with m_req held: M wins the next arbitration.
- A req that drops before grant is ignored. A req that drops after grant still completes and acks.
- Reset mid-access aborts the access immediately: no ack, bus inactive.
- The address is passed through unchanged; no wrap or width arithmetic.
- The starve counter saturates at MAX_REN_BURST.

Decomposition:
- Shared package/header vram_bus.vh: state encodings (IDLE=0, ACCESS=1, TURN=2) and the request-bundle field widths.
- No sub-module required. A per-port request mux/ack demux may live in a generate block.

Test Plan:
- Reset with r_req=1 asserted: all outputs at reset values. After _reset rises, the first grant goes to R.
- M read addr 0x0123, ACCESS_CYCLES=2, vram_data_in=0xBEEF on the sample cycle -> _vram_en and _vram_rd low for 2 cycles with vram_addr=0x0123; m_ack=1 and m_rdata=0xBEEF at cycle 3 after req.
- R write addr 0x0040, be=2'b01, data 0xA55A -> _vram_wr=0, _vram_be=2'b10, oe=1, vram_data_out=0xA55A for 2 cycles; r_ack pulse; one TURN cycle with oe=0.
- r_req and m_req held continuously, MAX_REN_BURST=4 -> grant order R,R,R,R,M,R,R,R,R,M; m_ack occurs within 5 accesses.
- _reset dropped in the middle of an M write -> bus inactive within the reset assertion; no m_ack; the next request completes normally.
- Random traffic with a bus monitor -> _vram_rd and _vram_wr never both 0; oe never high without _vram_wr=0; every granted req gets exactly one ack.
